nec_ir_receiver: RTL and testbench

- Decodes the demodulated IR sensor line (NEC protocol, as sent by the LG remote) into the 32-bit code word that the display and game-state logic compare against constants such as 32'h20DF_5BA4.
- Sits between the IR sensor pin and every consumer of ir_in.
- Holds the last valid code, flags NEC repeat frames, and releases the code to 0 after a period with no activity.

---
 rtl/nec_ir_receiver.sv | 183 ++++++++++++++++++
 tb/tb_nec_ir_receiver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_receiver.sv
// NEC IR receiver: synchronises the sensor line, times marks and spaces in microseconds,
// decodes 32-bit frames and repeat codes, and holds the last code until it is released.
module nec_ir_receiver #(
    parameter int unsigned CYCLES_PER_US = 74,
    parameter int unsigned RELEASE_MS    = 120,
    parameter int unsigned CHECK_INV     = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ir_rx_in,
    output logic [31:0] ir_out,
    output logic        valid_out,
    output logic        repeat_out,
    output logic        error_out
);
    localparam int unsigned   PW        = $clog2(CYCLES_PER_US + 1);
    localparam logic [PW-1:0] PrescLast = PW'(CYCLES_PER_US - 1);
    localparam logic [15:0]   RelLast   = 16'(RELEASE_MS - 1);

    typedef enum logic [2:0] {
        StIdle, StLeadMark, StLeadSpace, StBitMark, StBitSpace, StCommit
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   width_q, width_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [31:0]   code_q, code_d;
    logic          have_q, have_d;
    logic          valid_q, valid_d, rep_q, rep_d, err_q, err_d;
    logic [9:0]    rel_us_q, rel_us_d;
    logic [15:0]   rel_ms_q, rel_ms_d;

    logic        tick, fall, rise, edge_seen, bit_one, bit_zero, inv_ok, expire, rel_clr;
    logic [31:0] word;

    function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    assign tick      = (presc_q == PrescLast);
    assign fall      = prev_q & ~sync2_q;
    assign rise      = ~prev_q & sync2_q;
    assign edge_seen = fall | rise;
    assign presc_d   = tick ? '0 : presc_q + 1'b1;
    assign width_d   = edge_seen ? '0 : ((tick && width_q != '1) ? width_q + 1'b1 : width_q);
    assign bit_one   = in_win(width_q, 14'd1400, 14'd1900);
    assign bit_zero  = in_win(width_q, 14'd400, 14'd750);
    assign word      = {shreg_q[30:0], bit_one};
    assign inv_ok    = (CHECK_INV == 0) || (word[7:0] == ~word[15:8]);
    assign expire    = have_q && tick && (rel_us_q == 10'd999) && (rel_ms_q == RelLast)
                       && (RELEASE_MS != 0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        code_d    = code_q;
        have_d    = have_q;
        valid_d   = 1'b0;
        rep_d     = 1'b0;
        err_d     = 1'b0;
        rel_clr   = 1'b0;
        // Expiry is applied first so a commit or repeat below overrides it.
        if (expire) begin
            code_d = '0;
            have_d = 1'b0;
        end
        unique case (state_q)
            StIdle: if (fall) state_d = StLeadMark;
            StLeadMark: if (rise) begin
                if (in_win(width_q, 14'd8000, 14'd10000)) state_d = StLeadSpace;
                else err_d = 1'b1;
            end
            StLeadSpace: if (fall) begin
                if (in_win(width_q, 14'd4000, 14'd5000)) begin
                    state_d   = StBitMark;
                    bit_cnt_d = '0;
                end else if (in_win(width_q, 14'd2000, 14'd2500)) begin
                    state_d = StIdle;
                    if (have_q) begin
                        rep_d   = 1'b1;
                        rel_clr = 1'b1;
                        code_d  = code_q;
                        have_d  = 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            StBitMark: if (rise) begin
                if (bit_zero) state_d = StBitSpace;
                else err_d = 1'b1;
            end
            StBitSpace: if (fall) begin
                if (bit_zero || bit_one) begin
                    shreg_d = word;
                    if (bit_cnt_q == 5'd31) begin
                        // Commit is registered on entry so outputs meet the 3-cycle latency.
                        state_d = StCommit;
                        if (inv_ok) begin
                            code_d  = word;
                            valid_d = 1'b1;
                            have_d  = 1'b1;
                            rel_clr = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = StBitMark;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (state_q != StIdle && state_q != StCommit && !edge_seen && width_q > 14'd11000) begin
            err_d = 1'b1;
        end
        if (err_d) state_d = StIdle;

        rel_us_d = rel_us_q;
        rel_ms_d = rel_ms_q;
        if (!have_d || rel_clr) begin
            rel_us_d = '0;
            rel_ms_d = '0;
        end else if (tick) begin
            if (rel_us_q == 10'd999) begin
                rel_us_d = '0;
                rel_ms_d = rel_ms_q + 1'b1;
            end else begin
                rel_us_d = rel_us_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            presc_q   <= '0;
            width_q   <= '0;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            code_q    <= '0;
            have_q    <= 1'b0;
            valid_q   <= 1'b0;
            rep_q     <= 1'b0;
            err_q     <= 1'b0;
            rel_us_q  <= '0;
            rel_ms_q  <= '0;
        end else begin
            sync1_q   <= ir_rx_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            presc_q   <= presc_d;
            width_q   <= width_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= err_d ? '0 : shreg_d;
            code_q    <= code_d;
            have_q    <= have_d;
            valid_q   <= valid_d;
            rep_q     <= rep_d;
            err_q     <= err_d;
            rel_us_q  <= rel_us_d;
            rel_ms_q  <= rel_ms_d;
        end
    end

    assign ir_out     = code_q;
    assign valid_out  = valid_q;
    assign repeat_out = rep_q;
    assign error_out  = err_q;
endmodule

// File: tb/tb_nec_ir_receiver.sv
// Directed bench for nec_ir_receiver: nominal frames, repeats, release, error and reset cases.
module tb_nec_ir_receiver;
    localparam int unsigned CPU = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_rx = 1'b1;
    logic [31:0] ir_out;
    logic        valid_out, repeat_out, error_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_rep    = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    nec_ir_receiver #(
        .CYCLES_PER_US(CPU),
        .RELEASE_MS   (120),
        .CHECK_INV    (1)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst_n),
        .ir_rx_in  (ir_rx),
        .ir_out    (ir_out),
        .valid_out (valid_out),
        .repeat_out(repeat_out),
        .error_out (error_out)
    );

    always @(negedge clk) begin
        if (valid_out)  n_valid <= n_valid + 1;
        if (repeat_out) n_rep   <= n_rep + 1;
        if (error_out)  n_err   <= n_err + 1;
    end

    // Drive a level for a number of microseconds; always returns 1 time unit after a posedge.
    task automatic hold(input logic lvl, input int us);
        ir_rx = lvl;
        repeat (us * CPU) @(posedge clk);
        #1;
    endtask

    task automatic send_leader(input int space_us);
        hold(1'b0, 9000);
        hold(1'b1, space_us);
    endtask

    task automatic send_bits(input logic [31:0] code, input int nbits, input int bad_idx,
                             input int bad_us);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 562);
            if (i == bad_idx)    hold(1'b1, bad_us);
            else if (code[31-i]) hold(1'b1, 1687);
            else                 hold(1'b1, 562);
        end
    endtask

    task automatic end_mark();
        hold(1'b0, 560);
        hold(1'b1, 2000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ir_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ir_out !== 32'h0) $display("FAIL reset_ir_out: got %h expected 00000000", ir_out);
        else n_pass++;
        n_checks++;
        if ({valid_out, repeat_out, error_out} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {valid_out, repeat_out, error_out});
        else n_pass++;
        rst_n = 1'b1;
        hold(1'b1, 100);
    endtask

    task automatic test_repeat_no_code();
        int v0, r0, e0;
        v0 = n_valid; r0 = n_rep; e0 = n_err;
        send_leader(2250);
        end_mark();
        n_checks++;
        if ((n_valid - v0) + (n_rep - r0) + (n_err - e0) != 0)
            $display("FAIL repeat_no_code: got %0d pulses expected 0",
                     (n_valid - v0) + (n_rep - r0) + (n_err - e0));
        else n_pass++;
    endtask

    task automatic test_valid_frame(input logic [31:0] code, input string name);
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_leader(4500);
        send_bits(code, 32, -1, 0);
        ir_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL %s early: valid_out=%b expected 0", name, valid_out);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b1) $display("FAIL %s pulse: valid_out=%b expected 1", name, valid_out);
        else n_pass++;
        n_checks++;
        if (ir_out !== code) $display("FAIL %s code: ir_out=%h expected %h", name, ir_out, code);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL %s late: valid_out=%b expected 0", name, valid_out);
        else n_pass++;
        end_mark();
        n_checks++;
        if (n_valid - v0 != 1 || n_err != e0)
            $display("FAIL %s counts: valid=%0d err=%0d expected 1 and 0", name,
                     n_valid - v0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_repeat_held();
        int r0;
        hold(1'b1, 40000);
        r0 = n_rep;
        send_leader(2250);
        ir_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (repeat_out !== 1'b0) $display("FAIL rep_early: repeat_out=%b expected 0", repeat_out);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (repeat_out !== 1'b1) $display("FAIL rep_pulse: repeat_out=%b expected 1", repeat_out);
        else n_pass++;
        end_mark();
        n_checks++;
        if (n_rep - r0 != 1) $display("FAIL rep_count: got %0d expected 1", n_rep - r0);
        else n_pass++;
        n_checks++;
        if (ir_out !== 32'h20DF5BA4) $display("FAIL rep_code: ir_out=%h expected 20df5ba4", ir_out);
        else n_pass++;
    endtask

    task automatic test_release();
        int r0;
        hold(1'b1, 115000);
        n_checks++;
        if (ir_out !== 32'h20DF5BA4)
            $display("FAIL release_early: ir_out=%h expected 20df5ba4", ir_out);
        else n_pass++;
        hold(1'b1, 4000);
        n_checks++;
        if (ir_out !== 32'h0) $display("FAIL release_clear: ir_out=%h expected 00000000", ir_out);
        else n_pass++;
        r0 = n_rep;
        send_leader(2250);
        end_mark();
        n_checks++;
        if (n_rep != r0) $display("FAIL release_repeat: got %0d pulses expected 0", n_rep - r0);
        else n_pass++;
    endtask

    task automatic test_inv_mismatch();
        int v0;
        v0 = n_valid;
        send_leader(4500);
        send_bits(32'h20DF5BA5, 32, -1, 0);
        ir_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (error_out !== 1'b1) $display("FAIL inv_error: error_out=%b expected 1", error_out);
        else n_pass++;
        end_mark();
        n_checks++;
        if (n_valid != v0) $display("FAIL inv_valid: got %0d pulses expected 0", n_valid - v0);
        else n_pass++;
        n_checks++;
        if (ir_out !== 32'h20DF5BA4) $display("FAIL inv_code: ir_out=%h expected 20df5ba4", ir_out);
        else n_pass++;
    endtask

    task automatic test_bad_bit();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_leader(4500);
        send_bits(32'h20DF5AA5, 8, 7, 1200);
        end_mark();
        hold(1'b1, 1000);
        n_checks++;
        if (n_err - e0 != 1 || n_valid != v0)
            $display("FAIL bad_bit: err=%0d valid=%0d expected 1 and 0", n_err - e0, n_valid - v0);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_leader(4500);
        send_bits(32'h20DF5BA4, 10, -1, 0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ir_out !== 32'h0 || {valid_out, repeat_out, error_out} !== 3'b000)
            $display("FAIL midreset: ir_out=%h flags=%b expected 00000000 000", ir_out,
                     {valid_out, repeat_out, error_out});
        else n_pass++;
        hold(1'b1, 10);
        rst_n = 1'b1;
        hold(1'b1, 1000);
        test_valid_frame(32'h20DF5BA4, "frame_after_reset");
    endtask

    initial begin
        test_reset();
        test_repeat_no_code();
        test_valid_frame(32'h20DF5BA4, "frame_5ba4");
        test_repeat_held();
        test_release();
        test_valid_frame(32'h20DF5BA4, "frame_before_inv");
        test_inv_mismatch();
        test_bad_bit();
        test_valid_frame(32'h20DF5AA5, "frame_after_err");
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
